// File: rtl/counter_share_sched_if.sv
// Bus between timing clients and the shared-counter scheduler.
// The master side drives requests, lengths and hold; the slave side drives grant, done and counter status.
interface counter_share_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0]       i_req;
    logic [NREQ*WIDTH-1:0] i_len;
    logic                  i_hold;
    logic [NREQ-1:0]       o_grant;
    logic [NREQ-1:0]       o_done;
    logic [IDXW-1:0]       o_owner;
    logic                  o_busy;
    logic [WIDTH-1:0]      o_count;

    modport master (
        output i_req, i_len, i_hold,
        input  o_grant, o_done, o_owner, o_busy, o_count
    );

    modport slave (
        input  i_req, i_len, i_hold,
        output o_grant, o_done, o_owner, o_busy, o_count
    );
endinterface

// File: rtl/counter_share_sched.sv
// Round-robin scheduler that lends one up-counter to NREQ requesters in turn,
// runs it to the owner's latched length and pulses that owner's done.
module counter_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_share_sched_if.slave bus
);
    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_rr;
    logic [IDXW-1:0]  r_owner;
    logic [WIDTH-1:0] r_len;
    logic [WIDTH-1:0] r_count;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic             r_busy;

    logic             w_pickValid;
    logic [IDXW-1:0]  w_pick;
    logic [NREQ-1:0]  w_pickOneHot;
    logic [IDXW-1:0]  w_nextRr;
    logic [WIDTH:0]   w_countInc;
    logic [WIDTH-1:0] w_pickLen;

    // Scan from the highest offset down so the closest requester at/after r_rr wins.
    always_comb begin
        logic [IDXW-1:0] cand;
        cand        = '0;
        w_pickValid = 1'b0;
        w_pick      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDXW'((int'(r_rr) + k) % NREQ);
            if (bus.i_req[cand]) begin
                w_pickValid = 1'b1;
                w_pick      = cand;
            end
        end
    end

    assign w_pickOneHot = NREQ'(1) << w_pick;
    assign w_pickLen    = bus.i_len[int'(w_pick)*WIDTH +: WIDTH];
    assign w_nextRr     = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_countInc   = {1'b0, r_count} + (WIDTH+1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_owner <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        r_state <= GRANT;
                        r_owner <= w_pick;
                        r_len   <= w_pickLen;
                        r_grant <= w_pickOneHot;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end
                end
                GRANT: begin
                    if (r_len == '0) begin
                        r_state <= DONE;
                        r_done  <= r_grant;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Losing the request beats both hold and reaching the length.
                    if (!bus.i_req[r_owner]) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_rr    <= w_nextRr;
                    end else if (!bus.i_hold) begin
                        r_count <= w_countInc[WIDTH-1:0];
                        if (w_countInc == {1'b0, r_len}) begin
                            r_state <= DONE;
                            r_done  <= r_grant;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                    r_rr    <= w_nextRr;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_grant = r_grant;
    assign bus.o_done  = r_done;
    assign bus.o_owner = r_owner;
    assign bus.o_busy  = r_busy;
    assign bus.o_count = r_count;
endmodule
